// File: rtl/execute_cycle.sv
// execute_cycle: execute (E) stage of the 5-stage pipeline.
//   Forwards operands, runs the ALU, resolves branches and registers the
//   E/M pipeline signals. MUL runs on an iterative shift-add multiplier that
//   retires MUL_BITS_PER_CYCLE multiplier bits per clock; while it is running
//   StallE holds the front end and bubbles are written into M.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   RegWriteE..JumpE              decoded controls (all zero = bubble)
//   ALUControlE                   operation select (0..9, others = ADD)
//   RD1_E, RD2_E, Imm_Ext_E       register operands and immediate
//   PCE, PCPlus4E                 PC values of the instruction in E
//   RD_E                          destination register
//   ForwardA_E, ForwardB_E        forwarding selects (00 RF, 01 W, 10 M)
//   ResultW                       writeback value for forwarding
//   RegWriteM..ALU_ResultM        registered E/M outputs
//   PCSrcE, PCTargetE             combinational redirect and target
//   StallE                        high while a MUL occupies E, not complete
module execute_cycle #(
  parameter int unsigned DATA_W             = 32,
  parameter int unsigned REG_ADDR_W         = 6,
  parameter int unsigned MUL_BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteE,
  input  logic                  MemWriteE,
  input  logic                  ResultSrcE,
  input  logic                  ALUSrcE,
  input  logic                  BranchE,
  input  logic                  JumpE,
  input  logic [3:0]            ALUControlE,
  input  logic [DATA_W-1:0]     RD1_E,
  input  logic [DATA_W-1:0]     RD2_E,
  input  logic [DATA_W-1:0]     Imm_Ext_E,
  input  logic [DATA_W-1:0]     PCE,
  input  logic [DATA_W-1:0]     PCPlus4E,
  input  logic [REG_ADDR_W-1:0] RD_E,
  input  logic [1:0]            ForwardA_E,
  input  logic [1:0]            ForwardB_E,
  input  logic [DATA_W-1:0]     ResultW,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic                  ResultSrcM,
  output logic [REG_ADDR_W-1:0] RD_M,
  output logic [DATA_W-1:0]     PCPlus4M,
  output logic [DATA_W-1:0]     WriteDataM,
  output logic [DATA_W-1:0]     ALU_ResultM,
  output logic                  PCSrcE,
  output logic [DATA_W-1:0]     PCTargetE,
  output logic                  StallE
);

  localparam int unsigned MUL_ITERS = DATA_W / MUL_BITS_PER_CYCLE;
  localparam int unsigned CNT_W     = $clog2(MUL_ITERS + 1);

  typedef enum logic {IDLE, BUSY} mul_state_t;

  mul_state_t              state, state_next;
  logic [DATA_W-1:0]       src_a, src_b, write_data, alu_result, diff;
  logic                    zero;
  logic                    mul_start, mul_done;
  logic [CNT_W-1:0]        mul_cnt;
  logic [DATA_W-1:0]       mul_acc, mul_mcand, mul_mplier, step_acc;
  logic                    mul_rw, mul_mw, mul_rs;
  logic [REG_ADDR_W-1:0]   mul_rd;
  logic [DATA_W-1:0]       mul_pc4, mul_wd;

  always_comb begin
    case (ForwardA_E)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALU_ResultM;
      default: src_a = RD1_E;
    endcase
    case (ForwardB_E)
      2'b01:   write_data = ResultW;
      2'b10:   write_data = ALU_ResultM;
      default: write_data = RD2_E;
    endcase
    src_b = ALUSrcE ? Imm_Ext_E : write_data;
  end

  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      4'd1:    alu_result = src_a - src_b;
      4'd2:    alu_result = src_a & src_b;
      4'd3:    alu_result = src_a | src_b;
      4'd4:    alu_result = src_a ^ src_b;
      4'd5:    alu_result[0] = $signed(src_a) < $signed(src_b);
      4'd6:    alu_result = src_a << src_b[4:0];
      4'd7:    alu_result = src_a >> src_b[4:0];
      4'd8:    alu_result = $signed(src_a) >>> src_b[4:0];
      default: alu_result = src_a + src_b;
    endcase
  end

  assign diff      = src_a - src_b;
  assign zero      = (diff == '0);
  assign PCSrcE    = JumpE | (BranchE & zero);
  assign PCTargetE = PCE + Imm_Ext_E;

  // One shift-add step: add the multiplicand for every set multiplier bit
  // of the current digit.
  always_comb begin
    step_acc = mul_acc;
    for (int unsigned i = 0; i < MUL_BITS_PER_CYCLE; i++) begin
      if (mul_mplier[i]) step_acc = step_acc + (mul_mcand << i);
    end
  end

  // The arrival cycle counts as the first stall cycle; the last BUSY cycle
  // (counter at 1) drops StallE and writes the final step's sum into M.
  always_comb begin
    mul_start  = (state == IDLE) && (ALUControlE == 4'd9);
    mul_done   = (state == BUSY) && (mul_cnt == CNT_W'(1));
    StallE     = mul_start || ((state == BUSY) && (mul_cnt > CNT_W'(1)));
    state_next = state;
    case (state)
      IDLE:    if (mul_start) state_next = BUSY;
      BUSY:    if (mul_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mul_cnt     <= '0;
      mul_acc     <= '0;
      mul_mcand   <= '0;
      mul_mplier  <= '0;
      mul_rw      <= 1'b0;
      mul_mw      <= 1'b0;
      mul_rs      <= 1'b0;
      mul_rd      <= '0;
      mul_pc4     <= '0;
      mul_wd      <= '0;
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else begin
      state <= state_next;

      if (mul_start) begin
        mul_mcand  <= src_a;
        mul_mplier <= src_b;
        mul_acc    <= '0;
        mul_cnt    <= CNT_W'(MUL_ITERS);
        mul_rw     <= RegWriteE;
        mul_mw     <= MemWriteE;
        mul_rs     <= ResultSrcE;
        mul_rd     <= RD_E;
        mul_pc4    <= PCPlus4E;
        mul_wd     <= write_data;
      end else if (state == BUSY) begin
        mul_acc    <= step_acc;
        mul_mcand  <= mul_mcand << MUL_BITS_PER_CYCLE;
        mul_mplier <= mul_mplier >> MUL_BITS_PER_CYCLE;
        mul_cnt    <= mul_cnt - CNT_W'(1);
      end

      if (StallE) begin
        RegWriteM   <= 1'b0;
        MemWriteM   <= 1'b0;
        ResultSrcM  <= 1'b0;
        RD_M        <= '0;
        PCPlus4M    <= '0;
        WriteDataM  <= '0;
        ALU_ResultM <= '0;
      end else if (mul_done) begin
        RegWriteM   <= mul_rw;
        MemWriteM   <= mul_mw;
        ResultSrcM  <= mul_rs;
        RD_M        <= mul_rd;
        PCPlus4M    <= mul_pc4;
        WriteDataM  <= mul_wd;
        ALU_ResultM <= step_acc;
      end else begin
        RegWriteM   <= RegWriteE;
        MemWriteM   <= MemWriteE;
        ResultSrcM  <= ResultSrcE;
        RD_M        <= RD_E;
        PCPlus4M    <= PCPlus4E;
        WriteDataM  <= write_data;
        ALU_ResultM <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle: scoreboard bench for execute_cycle. The driver computes
// the expected E/M contents of every clock edge from an instruction-level
// model and queues them; a free-running monitor pops and compares.
module tb_execute_cycle;

  localparam int MB = 4;
  localparam int NI = 32 / MB;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [5:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        RegWriteM, MemWriteM, ResultSrcM, PCSrcE, StallE;
  logic [5:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM, PCTargetE;

  always #5 clk = ~clk;

  execute_cycle #(.DATA_W(32), .REG_ADDR_W(6), .MUL_BITS_PER_CYCLE(MB)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .ALUSrcE(ALUSrcE), .BranchE(BranchE), .JumpE(JumpE),
    .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .RD_E(RD_E),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
    .ALU_ResultM(ALU_ResultM), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallE(StallE)
  );

  typedef struct packed {
    logic        rw, mw, rs, alusrc, br, jmp;
    logic [3:0]  op;
    logic [31:0] rd1, rd2, imm, pc, resw;
    logic [5:0]  rd;
    logic [1:0]  fa, fb;
  } instr_t;

  typedef struct packed {
    logic        rw, mw, rs;
    logic [5:0]  rd;
    logic [31:0] pc4, wd, alu;
  } em_t;

  em_t         sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_alu = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    case (op)
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return a << b[4:0];
      4'd7: return a >> b[4:0];
      4'd8: return $signed(a) >>> b[4:0];
      4'd9: begin
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
      end
      default: return a + b;
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf,
                                      input logic [31:0] w, input logic [31:0] m);
    case (sel)
      2'b01:   return w;
      2'b10:   return m;
      default: return rf;
    endcase
  endfunction

  function automatic instr_t mk(input logic [3:0] op, input logic [31:0] rd1,
                                input logic [31:0] rd2, input logic [31:0] imm,
                                input logic alusrc, input logic [5:0] rd, input logic rw);
    instr_t t;
    t        = '0;
    t.op     = op;
    t.rd1    = rd1;
    t.rd2    = rd2;
    t.imm    = imm;
    t.alusrc = alusrc;
    t.rd     = rd;
    t.rw     = rw;
    t.pc     = 32'h0000_1000;
    return t;
  endfunction

  task automatic drive(input instr_t in);
    RegWriteE   = in.rw;
    MemWriteE   = in.mw;
    ResultSrcE  = in.rs;
    ALUSrcE     = in.alusrc;
    BranchE     = in.br;
    JumpE       = in.jmp;
    ALUControlE = in.op;
    RD1_E       = in.rd1;
    RD2_E       = in.rd2;
    Imm_Ext_E   = in.imm;
    PCE         = in.pc;
    PCPlus4E    = in.pc + 32'd4;
    RD_E        = in.rd;
    ForwardA_E  = in.fa;
    ForwardB_E  = in.fb;
    ResultW     = in.resw;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive('0);
    rst = 1'b1;
    #1;
    chk("stall_in_reset", {31'd0, StallE}, 32'd0);
    sb_q.push_back('0);
    cur_alu = '0;
  endtask

  // abort_at: occupancy cycle of a MUL in which rst is pulsed (0 = none).
  task automatic issue(input instr_t in, input int abort_at);
    logic [31:0] a, wd, b;
    em_t         r;
    instr_t      cur;
    a  = fwd(in.fa, in.rd1, in.resw, cur_alu);
    wd = fwd(in.fb, in.rd2, in.resw, cur_alu);
    b  = in.alusrc ? in.imm : wd;
    if (in.op == 4'd9) begin
      for (int k = 1; k <= NI + 1; k++) begin
        @(negedge clk);
        cur = in;
        if (k > 1) begin
          cur.resw = $urandom;
          cur.fa   = 2'($urandom_range(0, 3));
          cur.fb   = 2'($urandom_range(0, 3));
        end
        drive(cur);
        rst = (k == abort_at);
        #1;
        r = '0;
        if (k == abort_at) begin
          sb_q.push_back(r);
          cur_alu = '0;
          break;
        end
        chk("stall_mul", {31'd0, StallE}, (k <= NI) ? 32'd1 : 32'd0);
        if (k == NI + 1) begin
          r.rw  = in.rw;
          r.mw  = in.mw;
          r.rs  = in.rs;
          r.rd  = in.rd;
          r.pc4 = in.pc + 32'd4;
          r.wd  = wd;
          r.alu = ref_op(4'd9, a, b);
        end
        sb_q.push_back(r);
        cur_alu = r.alu;
      end
    end else begin
      @(negedge clk);
      drive(in);
      rst = 1'b0;
      #1;
      chk("stall_single", {31'd0, StallE}, 32'd0);
      chk("pcsrc", {31'd0, PCSrcE}, {31'd0, in.jmp | (in.br & (a == b))});
      chk("pctarget", PCTargetE, in.pc + in.imm);
      r.rw  = in.rw;
      r.mw  = in.mw;
      r.rs  = in.rs;
      r.rd  = in.rd;
      r.pc4 = in.pc + 32'd4;
      r.wd  = wd;
      r.alu = ref_op(in.op, a, b);
      sb_q.push_back(r);
      cur_alu = r.alu;
    end
  endtask

  initial begin : monitor
    em_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("em_ctl", {23'd0, RegWriteM, MemWriteM, ResultSrcM, RD_M},
            {23'd0, e.rw, e.mw, e.rs, e.rd});
        chk("em_alu", ALU_ResultM, e.alu);
        chk("em_wdata", WriteDataM, e.wd);
        chk("em_pc4", PCPlus4M, e.pc4);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin : stimulus
    instr_t t;
    rst = 1'b1;
    drive('0);
    do_reset();
    do_reset();

    issue('0, 0);

    t = mk(4'd0, 32'd7, 32'd0, 32'd0, 1'b0, 6'd2, 1'b1);
    issue(t, 0);
    t = mk(4'd0, 32'd5, 32'd0, 32'd0, 1'b0, 6'd3, 1'b1);
    t.fb = 2'b10;
    issue(t, 0);
    t = mk(4'd1, 32'd20, 32'd8, 32'd0, 1'b0, 6'd4, 1'b1);
    issue(t, 0);
    t = mk(4'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 6'd5, 1'b1);
    issue(t, 0);
    t = mk(4'd8, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 6'd6, 1'b1);
    issue(t, 0);
    t = mk(4'd0, 32'd0, 32'd3, 32'd0, 1'b0, 6'd7, 1'b1);
    t.fa   = 2'b01;
    t.resw = 32'd100;
    issue(t, 0);

    t = mk(4'd1, 32'd9, 32'd9, 32'h20, 1'b0, 6'd0, 1'b0);
    t.br = 1'b1;
    t.pc = 32'h100;
    issue(t, 0);
    t.rd2 = 32'd8;
    issue(t, 0);
    t.jmp = 1'b1;
    issue(t, 0);

    t = mk(4'd9, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b0, 6'd7, 1'b1);
    t.resw = 32'h1234_5678;
    issue(t, 0);
    issue(mk(4'd9, 32'd6, 32'd7, 32'd0, 1'b0, 6'd8, 1'b1), 0);
    issue(mk(4'd9, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 6'd9, 1'b1), 0);

    issue(mk(4'd9, 32'd123, 32'd456, 32'd0, 1'b0, 6'd10, 1'b1), 5);
    issue('0, 0);
    issue(mk(4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 6'd11, 1'b1), 0);

    for (int n = 0; n < 250; n++) begin
      t        = '0;
      t.op     = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) t.op = 4'd9;
      t.rw     = 1'($urandom);
      t.mw     = 1'($urandom);
      t.rs     = 1'($urandom);
      t.alusrc = 1'($urandom);
      t.br     = 1'($urandom);
      t.jmp    = ($urandom_range(0, 7) == 0);
      t.rd1    = $urandom;
      t.rd2    = ($urandom_range(0, 3) == 0) ? t.rd1 : $urandom;
      t.imm    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      t.pc     = $urandom & 32'hFFFF_FFFC;
      t.resw   = $urandom;
      t.rd     = 6'($urandom);
      t.fa     = 2'($urandom_range(0, 3));
      t.fb     = 2'($urandom_range(0, 3));
      issue(t, 0);
    end

    issue('0, 0);
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
Execute (E) stage of the 5-stage pipeline. It sits directly upstream of the memory stage and consumes the decode/execute register outputs. It performs operand forwarding, the ALU operation and branch resolution, then registers the E/M pipeline signals that the memory stage consumes. An iterative shift-add multiplier handles MUL; while it runs, the stage stalls the front end and inserts bubbles into M.

Parameters:
DATA_W, 32, datapath width; only 32 is supported.
REG_ADDR_W, 6, destination register index width.
MUL_BITS_PER_CYCLE, 1, multiplier bits retired per iteration; legal values 1, 2, 4. N = DATA_W / MUL_BITS_PER_CYCLE iterations.

Ports:
clk  in  1  stage clock
rst  in  1  synchronous, active-high reset
RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE  in  1 each  decoded controls; an all-zero set is a bubble
ALUControlE  in  4  operation select: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 SRL, 8 SRA, 9 MUL; 10-15 behave as ADD
RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  32 each  operands and PC values
RD_E  in  REG_ADDR_W  destination register
ForwardA_E, ForwardB_E  in  2 each  forwarding select: 00 register file, 01 ResultW, 10 ALU_ResultM, 11 treated as 00
ResultW  in  32  writeback result for forwarding
RegWriteM, MemWriteM, ResultSrcM  out  1 each  registered controls to M
RD_M  out  REG_ADDR_W  registered destination
PCPlus4M, WriteDataM, ALU_ResultM  out  32 each  registered values to M
PCSrcE  out  1  combinational redirect = JumpE | (BranchE & ZeroE)
PCTargetE  out  32  combinational PCE + Imm_Ext_E
StallE  out  1  combinational; high while a MUL occupies E and is not complete

Behaviour:
- Reset is synchronous. While rst is high at a clock edge, all registered outputs clear to 0, the multiplier FSM goes to IDLE and StallE is 0 the next cycle.
- SrcA is the forwarded A operand. WriteDataE is the forwarded B operand. SrcB is Imm_Ext_E when ALUSrcE is 1, otherwise WriteDataE.
- ZeroE is (SrcA - SrcB) == 0, evaluated for all ops.
- Single-cycle ops: results are mod 2^32. SLT is a signed compare that yields 0 or 1. Shift amount is SrcB[4:0]. SRA is arithmetic.
- Non-MUL ops have 1-cycle latency: the result appears on ALU_ResultM after the next edge.
- Multiplier FSM states: IDLE, BUSY.
  - IDLE to BUSY: when ALUControlE is 9 and the FSM is IDLE, latch SrcA, SrcB and the controls, clear the accumulator, set the counter to N, and drive StallE high that same cycle.
  - BUSY: each edge retires MUL_BITS_PER_CYCLE multiplier bits and decrements the counter. StallE stays high while counter > 0 after the update. It is high for exactly N cycles, counting the IDLE cycle in which the MUL arrives.
  - Completion: on cycle N+1 of the MUL's occupancy, StallE is low and the low 32 bits of the product go to the E/M register with the latched controls and RD. The FSM then returns to IDLE.
- During any StallE-high cycle, the E/M register loads a bubble: RegWriteM=0, MemWriteM=0, ResultSrcM=0, with other fields don't-care (0 preferred). The upstream stage holds its inputs constant; hazard logic uses StallE.
- Latched operands make the MUL immune to ForwardA_E/ForwardB_E and ResultW changes during BUSY.
- Back-to-back MULs: the second MUL is accepted in the cycle after the first completes. There are no idle gaps beyond that.
- rst asserted during BUSY aborts the MUL and no result is written.
- PCSrcE and PCTargetE are purely combinational. They are not gated by StallE, because a MUL is never a branch.

Test Plan:
- Reset: hold rst for 2 cycles -> all M outputs 0, StallE 0. Release, then present an all-zero bubble -> RegWriteM stays 0.
- ADD with forwarding: RD1_E=5, ForwardB_E=10, ALU_ResultM=7, ALUSrcE=0, RD_E=3, RegWriteE=1 -> next cycle ALU_ResultM=12, RD_M=3, RegWriteM=1. Repeat for SUB, SLT(-1,1)=1, SRA(0x80000000,4)=0xF8000000.
- Branch: BranchE=1, RD1_E=RD2_E=9, PCE=0x100, Imm=0x20 -> PCSrcE=1, PCTargetE=0x120 in the same cycle. With RD2_E=8 -> PCSrcE=0.
- MUL with MUL_BITS_PER_CYCLE=1: 0xFFFFFFFF*3, RD_E=7 -> StallE high 32 cycles with RegWriteM=0 each. On cycle 33, ALU_ResultM=0xFFFFFFFD, RD_M=7, RegWriteM=1. Change ResultW during BUSY -> no effect.
- Back-to-back MUL (6*7, then 0x10000*0x10000) with MUL_BITS_PER_CYCLE=4 -> each stalls 8 cycles; results 42 then 0.
- rst pulse at BUSY cycle 10 -> outputs 0 next cycle, StallE 0, no MUL result ever emitted.
